// File: rtl/ui_input_ctl_if.sv
// Player-input bundle between the raw board/mouse inputs and the screen-mode controller.
// master drives the raw inputs; slave (ui_input_ctl) drives the conditioned outputs.
interface ui_input_ctl_if;
    logic        button_in;
    logic        mouse_left_in;
    logic [11:0] xpos_in;
    logic [11:0] ypos_in;
    logic        vsync_in;
    logic        button_level;
    logic        button_pulse;
    logic        mouse_left_level;
    logic        mouse_click;
    logic [11:0] xpos_click;
    logic [11:0] ypos_click;

    modport master (
        output button_in, mouse_left_in, xpos_in, ypos_in, vsync_in,
        input  button_level, button_pulse, mouse_left_level, mouse_click,
               xpos_click, ypos_click
    );

    modport slave (
        input  button_in, mouse_left_in, xpos_in, ypos_in, vsync_in,
        output button_level, button_pulse, mouse_left_level, mouse_click,
               xpos_click, ypos_click
    );
endinterface

// File: rtl/ui_input_ctl.sv
// Push-button synchroniser/debouncer and single-shot mouse click detector with latched pointer.
// Define UI_CLICK_FRAME_ALIGN_EN to defer each click to the first vsync rise after the press.
module ui_input_ctl #(
    parameter int unsigned DEBOUNCE_CYCLES = 650000
) (
    input  logic         clk,
    input  logic         rst,
    ui_input_ctl_if.slave bus
);
    localparam int unsigned CNT_W = 24;
    localparam int unsigned POS_W = 12;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRE    = 2'd1,
        HELD    = 2'd2
`ifdef UI_CLICK_FRAME_ALIGN_EN
        ,
        WAIT_VS = 2'd3
`endif
    } state_e;

    logic             btn_s1_q, btn_s2_q;
    logic             ms_s1_q, ms_s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_level_q, btn_level_d;
    logic             btn_pulse_q, btn_pulse_d;
    state_e           state_q;
    logic             click_q;
    logic [POS_W-1:0] xpos_q, ypos_q;

    // Two-flop synchronisers for both asynchronous buttons
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
            ms_s1_q  <= 1'b0;
            ms_s2_q  <= 1'b0;
        end else begin
            btn_s1_q <= bus.button_in;
            btn_s2_q <= btn_s1_q;
            ms_s1_q  <= bus.mouse_left_in;
            ms_s2_q  <= ms_s1_q;
        end
    end

    // A new level is accepted only after persisting for DEBOUNCE_CYCLES consecutive edges
    always_comb begin
        cnt_d       = cnt_q;
        btn_level_d = btn_level_q;
        btn_pulse_d = 1'b0;
        if (btn_s2_q == btn_level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            btn_level_d = btn_s2_q;
            btn_pulse_d = btn_s2_q;
            cnt_d       = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            btn_level_q <= 1'b0;
            btn_pulse_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            btn_level_q <= btn_level_d;
            btn_pulse_q <= btn_pulse_d;
        end
    end

`ifdef UI_CLICK_FRAME_ALIGN_EN
    logic vs_q;

    always_ff @(posedge clk) begin
        if (rst) vs_q <= 1'b0;
        else     vs_q <= bus.vsync_in;
    end
`else
    logic unused_vsync_c;
    assign unused_vsync_c = bus.vsync_in;
`endif

    // Click FSM; click_q is set on the edge entering FIRE so it decodes FIRE exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            click_q <= 1'b0;
            xpos_q  <= '0;
            ypos_q  <= '0;
        end else begin
            click_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ms_s2_q) begin
                        xpos_q <= bus.xpos_in;
                        ypos_q <= bus.ypos_in;
`ifdef UI_CLICK_FRAME_ALIGN_EN
                        state_q <= WAIT_VS;
`else
                        state_q <= FIRE;
                        click_q <= 1'b1;
`endif
                    end
                end
`ifdef UI_CLICK_FRAME_ALIGN_EN
                WAIT_VS: begin
                    if (bus.vsync_in && !vs_q) begin
                        state_q <= FIRE;
                        click_q <= 1'b1;
                    end
                end
`endif
                FIRE: state_q <= HELD;
                HELD: begin
                    if (!ms_s2_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.button_level     = btn_level_q;
    assign bus.button_pulse     = btn_pulse_q;
    assign bus.mouse_left_level = ms_s2_q;
    assign bus.mouse_click      = click_q;
    assign bus.xpos_click       = xpos_q;
    assign bus.ypos_click       = ypos_q;
endmodule

// File: tb/tb_ui_input_ctl.sv
// Self-checking bench for ui_input_ctl: directed scenarios plus randomized traffic
// compared cycle by cycle against a history-based reference model.
module tb_ui_input_ctl;
    localparam int DEB = 16;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ui_input_ctl_if bus ();

    ui_input_ctl #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw sample histories and click bookkeeping
    bit          braw[$];
    bit          mraw[$];
    bit          bread[$];
    bit          e_level, e_pulse, e_mlevel, e_click;
    logic [11:0] e_x, e_y;
    bit          m_pending, m_wait_rel, m_prev_vs;

    task automatic model_edge(input bit r, input bit b, input bit m,
                              input logic [11:0] x, input logic [11:0] y, input bit vs);
        bit bs2, ms2, rise;
        int run;
        if (r) begin
            braw.delete(); mraw.delete(); bread.delete();
            e_level = 0; e_pulse = 0; e_mlevel = 0; e_click = 0;
            e_x = '0; e_y = '0;
            m_pending = 0; m_wait_rel = 0; m_prev_vs = 0;
            return;
        end
        // the synchronised level seen at this edge is the raw sample from two edges back
        bs2 = (braw.size() >= 2) ? braw[0] : 1'b0;
        ms2 = (mraw.size() >= 2) ? mraw[0] : 1'b0;
        braw.push_back(b); if (braw.size() > 2) void'(braw.pop_front());
        mraw.push_back(m); if (mraw.size() > 2) void'(mraw.pop_front());
        e_mlevel = (mraw.size() >= 2) ? mraw[0] : 1'b0;

        bread.push_back(bs2);
        if (bread.size() > DEB) void'(bread.pop_front());
        run = 0;
        for (int i = bread.size() - 1; i >= 0; i--) begin
            if (bread[i] == e_level) break;
            run++;
        end
        e_pulse = 0;
        if (run >= DEB) begin
            e_pulse = bs2;
            e_level = bs2;
            bread.delete();
        end

        rise = vs && !m_prev_vs;
        m_prev_vs = vs;
        if (e_click) begin
            e_click = 0;
            m_wait_rel = 1;
        end else if (m_wait_rel) begin
            if (!ms2) m_wait_rel = 0;
        end else if (m_pending) begin
            if (rise) begin
                m_pending = 0;
                e_click = 1;
            end
        end else if (ms2) begin
            e_x = x;
            e_y = y;
`ifdef UI_CLICK_FRAME_ALIGN_EN
            m_pending = 1;
`else
            e_click = 1;
`endif
        end
    endtask

    // One clock: inputs already driven, model updated with what the edge sampled, outputs settled
    task automatic advance();
        bit r, b, m, vs;
        logic [11:0] x, y;
        r = rst; b = bus.button_in; m = bus.mouse_left_in;
        x = bus.xpos_in; y = bus.ypos_in; vs = bus.vsync_in;
        @(posedge clk);
        model_edge(r, b, m, x, y, vs);
        #1;
    endtask

    function automatic logic [27:0] dut_out();
        return {bus.button_level, bus.button_pulse, bus.mouse_left_level, bus.mouse_click,
                bus.xpos_click, bus.ypos_click};
    endfunction

    function automatic logic [27:0] exp_out();
        return {e_level, e_pulse, e_mlevel, e_click, e_x, e_y};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.button_in = 1'($urandom); bus.mouse_left_in = 1'($urandom);
            bus.xpos_in = 12'($urandom); bus.ypos_in = 12'($urandom);
            bus.vsync_in = 1'($urandom);
            advance();
            checks++;
            if (dut_out() !== 28'd0) begin
                failures++;
                $display("FAIL reset_hold[%0d]: got=%h exp=0", i, dut_out());
            end
        end
        rst = 1'b0;
        advance();
        checks++;
        if (dut_out() !== 28'd0) begin
            failures++;
            $display("FAIL reset_release: got=%h exp=0", dut_out());
        end
        bus.button_in = 0; bus.mouse_left_in = 0; bus.vsync_in = 0;
        for (int i = 0; i < 40; i++) begin
            advance();
            checks++;
            if (dut_out() !== exp_out()) begin
                failures++;
                $display("FAIL reset_settle[%0d]: got=%h exp=%h", i, dut_out(), exp_out());
            end
        end
    endtask

    task automatic test_debounce();
        int rise_at, pulses, rises;
        for (int i = 0; i < 40; i++) begin
            bus.button_in = ((i / 5) % 2) == 0;
            advance();
            checks++;
            if (dut_out() !== exp_out()) begin
                failures++;
                $display("FAIL debounce_bounce[%0d]: got=%h exp=%h", i, dut_out(), exp_out());
            end
        end
        bus.button_in = 1'b1;
        rise_at = -1; pulses = 0;
        for (int k = 1; k <= 30; k++) begin
            advance();
            checks++;
            if (dut_out() !== exp_out()) begin
                failures++;
                $display("FAIL debounce_hold[%0d]: got=%h exp=%h", k, dut_out(), exp_out());
            end
            if (bus.button_level && rise_at < 0) rise_at = k;
            pulses += int'(bus.button_pulse);
        end
        checks++;
        if (rise_at !== 18) begin
            failures++;
            $display("FAIL debounce_latency: got=%0d edges exp=18", rise_at);
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL debounce_pulse_count: got=%0d exp=1", pulses);
        end
        // release, then a run of DEB-1 (rejected), then a run of exactly DEB (accepted)
        pulses = 0; rises = 0;
        for (int ph = 0; ph < 3; ph++) begin
            for (int k = 0; k < 30 + ((ph == 0) ? 0 : 16); k++) begin
                bus.button_in = (ph == 1) ? (k < DEB - 1) : (ph == 2) ? (k < DEB) : 1'b0;
                advance();
                checks++;
                if (dut_out() !== exp_out()) begin
                    failures++;
                    $display("FAIL debounce_run%0d[%0d]: got=%h exp=%h", ph, k, dut_out(), exp_out());
                end
                pulses += int'(bus.button_pulse);
                if (ph == 1) rises += int'(bus.button_level);
            end
            if (ph == 0) begin
                checks++;
                if (pulses !== 0 || bus.button_level !== 1'b0) begin
                    failures++;
                    $display("FAIL debounce_release: got pulses=%0d level=%b exp 0/0", pulses, bus.button_level);
                end
            end
        end
        checks++;
        if (rises !== 0 || pulses !== 1) begin
            failures++;
            $display("FAIL debounce_boundary: got short_run_level=%0d pulses=%0d exp 0/1", rises, pulses);
        end
    endtask

    task automatic test_click();
        int clicks, click_at;
        bus.mouse_left_in = 0; bus.vsync_in = 0;
        repeat (5) advance();
        bus.xpos_in = 12'd400; bus.ypos_in = 12'd90; bus.mouse_left_in = 1'b1;
        clicks = 0; click_at = -1;
        for (int k = 1; k <= 200; k++) begin
            if (k == 6) bus.xpos_in = 12'd500;
            advance();
            checks++;
            if (dut_out() !== exp_out()) begin
                failures++;
                $display("FAIL click[%0d]: got=%h exp=%h", k, dut_out(), exp_out());
            end
            if (bus.mouse_click) begin
                clicks++;
                click_at = k;
            end
        end
        checks++;
        if (bus.xpos_click !== 12'd400 || bus.ypos_click !== 12'd90) begin
            failures++;
            $display("FAIL click_coords: got=%0d,%0d exp=400,90", bus.xpos_click, bus.ypos_click);
        end
`ifndef UI_CLICK_FRAME_ALIGN_EN
        checks++;
        if (clicks !== 1 || click_at !== 3) begin
            failures++;
            $display("FAIL click_latency: got count=%0d at=%0d exp 1 at 3", clicks, click_at);
        end
`endif
        bus.mouse_left_in = 0;
        repeat (5) advance();
    endtask

    task automatic test_held();
        int clicks;
        clicks = 0;
        for (int ph = 0; ph < 3; ph++) begin
            bus.mouse_left_in = (ph != 1);
            for (int k = 0; k < ((ph == 0) ? 10000 : (ph == 1) ? 10 : 200); k++) begin
                bus.vsync_in = (k % 100) < 3;
                bus.xpos_in = 12'($urandom); bus.ypos_in = 12'($urandom);
                advance();
                if (dut_out() !== exp_out()) begin
                    failures++;
                    $display("FAIL held[%0d/%0d]: got=%h exp=%h", ph, k, dut_out(), exp_out());
                end
                checks++;
                clicks += int'(bus.mouse_click);
            end
            if (ph == 0) begin
                checks++;
                if (clicks !== 1) begin
                    failures++;
                    $display("FAIL held_single: got=%0d clicks exp=1", clicks);
                end
            end
        end
        checks++;
        if (clicks !== 2) begin
            failures++;
            $display("FAIL held_second_press: got=%0d clicks exp=2", clicks);
        end
        bus.mouse_left_in = 0; bus.vsync_in = 0;
        repeat (5) advance();
    endtask

`ifdef UI_CLICK_FRAME_ALIGN_EN
    task automatic test_frame_align();
        int clicks, click_at, k;
        bus.mouse_left_in = 0; bus.vsync_in = 0;
        repeat (5) advance();
        clicks = 0; click_at = -1; k = 0;
        bus.mouse_left_in = 1'b1;
        // press seen at the third edge; a vsync rise on that same edge must be ignored
        for (int i = 0; i < 12; i++) begin
            if (i == 1) bus.mouse_left_in = 1'b0;
            bus.vsync_in = (i >= 2 && i < 6) || (i >= 8);
            advance();
            k++;
            checks++;
            if (dut_out() !== exp_out()) begin
                failures++;
                $display("FAIL frame_align[%0d]: got=%h exp=%h", i, dut_out(), exp_out());
            end
            if (bus.mouse_click) begin
                clicks++;
                click_at = i;
            end
        end
        checks++;
        if (clicks !== 1 || click_at !== 8) begin
            failures++;
            $display("FAIL frame_align_timing: got count=%0d at=%0d exp 1 at 8", clicks, click_at);
        end
        bus.vsync_in = 0;
        repeat (5) advance();
    endtask
`endif

    task automatic test_reset_mid();
        int clicks, rise_at;
        bus.mouse_left_in = 1'b1; bus.vsync_in = 0;
`ifdef UI_CLICK_FRAME_ALIGN_EN
        repeat (3) advance();
`else
        repeat (2) advance();
`endif
        rst = 1'b1; bus.mouse_left_in = 1'b0;
        advance();
        rst = 1'b0;
        clicks = 0;
        for (int k = 0; k < 40; k++) begin
            bus.vsync_in = (k % 4) < 2;
            advance();
            checks++;
            if (dut_out() !== exp_out()) begin
                failures++;
                $display("FAIL reset_mid_click[%0d]: got=%h exp=%h", k, dut_out(), exp_out());
            end
            clicks += int'(bus.mouse_click);
        end
        checks++;
        if (clicks !== 0) begin
            failures++;
            $display("FAIL reset_mid_click_pulse: got=%0d clicks exp=0", clicks);
        end
        // reset part-way through a debounce restarts the full count
        bus.vsync_in = 0; bus.button_in = 1'b1;
        repeat (10) advance();
        rst = 1'b1;
        advance();
        rst = 1'b0;
        rise_at = -1;
        for (int k = 1; k <= 25; k++) begin
            advance();
            if (bus.button_level && rise_at < 0) rise_at = k;
        end
        checks++;
        if (rise_at !== 18) begin
            failures++;
            $display("FAIL reset_mid_debounce: got rise at %0d exp=18", rise_at);
        end
        bus.button_in = 0;
        repeat (40) advance();
    endtask

    task automatic test_random();
        int mrun, brun;
        mrun = 0; brun = 0;
        for (int k = 0; k < 3000; k++) begin
            if (mrun == 0) begin
                bus.mouse_left_in = ~bus.mouse_left_in;
                mrun = $urandom_range(1, 30);
            end
            if (brun == 0) begin
                bus.button_in = ~bus.button_in;
                brun = $urandom_range(1, 25);
            end
            mrun--; brun--;
            bus.xpos_in = 12'($urandom); bus.ypos_in = 12'($urandom);
            bus.vsync_in = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 499) == 0);
            advance();
            checks++;
            if (dut_out() !== exp_out()) begin
                failures++;
                $display("FAIL random[%0d]: got=%h exp=%h", k, dut_out(), exp_out());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        bus.button_in = 0; bus.mouse_left_in = 0; bus.vsync_in = 0;
        bus.xpos_in = '0; bus.ypos_in = '0;
        test_reset();
        test_debounce();
        test_click();
        test_held();
`ifdef UI_CLICK_FRAME_ALIGN_EN
        test_frame_align();
`endif
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
